// File: rtl/platform_scroller.sv
// Scans platform slots after each falling frame tick, reports the landed slot,
// and meters the resulting scroll distance out in MAX_STEP-limited per-frame steps.
module platform_scroller #(
  parameter int N_PLAT      = 8,
  parameter int SCROLL_LINE = 520,
  parameter int DOODLE_H    = 80,
  parameter int DOODLE_W    = 61,
  parameter int PLAT_W      = 80,
  parameter int HIT_TOL     = 30,
  parameter int GROUND_Y    = 767,
  parameter int MAX_STEP    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              frame_tick,
  input  logic                              falling,
  input  logic [10:0]                       doodle_x,
  input  logic [9:0]                        doodle_y,
  input  logic [N_PLAT-1:0][9:0]            plat_y,
  input  logic [N_PLAT-1:0][10:0]           plat_x,
  output logic [9:0]                        delta,
  output logic                              scroll_active,
  output logic                              hit_valid,
  output logic [$clog2(N_PLAT)-1:0]         hit_idx
);

  localparam int IDX_W = $clog2(N_PLAT);

  localparam logic signed [12:0] DH  = 13'(DOODLE_H);
  localparam logic signed [12:0] DW  = 13'(DOODLE_W);
  localparam logic signed [12:0] PW  = 13'(PLAT_W);
  localparam logic signed [12:0] TOL = 13'(HIT_TOL);
  localparam logic signed [12:0] GY  = 13'(GROUND_Y);
  localparam logic [9:0]         STEP_MAX = 10'(MAX_STEP);
  localparam logic [9:0]         LINE     = 10'(SCROLL_LINE);

  typedef enum logic [1:0] {IDLE, SCAN, EVAL} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W-1:0]  hit_slot;
  logic              hit_flag;
  logic [10:0]       dx_l;
  logic [9:0]        dy_l;
  logic [9:0]        remaining;

  logic              start, scan_en, eval_en, scan_last;
  logic              slot_hit;
  logic signed [12:0] py, px, dys, dxs;
  logic [9:0]        step, add;
  logic [11:0]       rem_sum;
  logic [9:0]        rem_nxt;

  assign scan_last = (scan_idx == IDX_W'(N_PLAT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_tick && falling) state_nxt = SCAN;
      SCAN:    if (scan_last) state_nxt = EVAL;
      EVAL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start   = 1'b0;
    scan_en = 1'b0;
    eval_en = 1'b0;
    case (state)
      IDLE:    start   = frame_tick && falling;
      SCAN:    scan_en = 1'b1;
      EVAL:    eval_en = 1'b1;
      default: ;
    endcase
  end

  // Zero-extended into 13-bit signed so the left bound may go negative without wrapping.
  always_comb begin
    py  = $signed({3'b000, plat_y[scan_idx]});
    px  = $signed({2'b00,  plat_x[scan_idx]});
    dys = $signed({3'b000, dy_l}) + DH;
    dxs = $signed({2'b00,  dx_l});
    slot_hit = (dys >= py) && (dys <= py + TOL) &&
               (((dxs >= px - DW) && (dxs <= px + PW)) || (py >= GY));
  end

  always_comb begin
    step    = (remaining > STEP_MAX) ? STEP_MAX : remaining;
    add     = (eval_en && hit_flag && (dy_l <= LINE)) ? (LINE - dy_l) : 10'd0;
    rem_sum = {2'b00, remaining} - (frame_tick ? {2'b00, step} : 12'd0) + {2'b00, add};
    rem_nxt = (rem_sum > 12'd1023) ? 10'd1023 : rem_sum[9:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx  <= '0;
      hit_slot  <= '0;
      hit_flag  <= 1'b0;
      dx_l      <= '0;
      dy_l      <= '0;
      remaining <= '0;
      delta     <= '0;
      hit_valid <= 1'b0;
      hit_idx   <= '0;
    end else begin
      if (start) begin
        dx_l     <= doodle_x;
        dy_l     <= doodle_y;
        hit_flag <= 1'b0;
        scan_idx <= '0;
      end
      if (scan_en) begin
        scan_idx <= scan_idx + IDX_W'(1);
        // First hit in index order wins.
        if (slot_hit && !hit_flag) begin
          hit_flag <= 1'b1;
          hit_slot <= scan_idx;
        end
      end
      hit_valid <= eval_en && hit_flag;
      if (eval_en && hit_flag) hit_idx <= hit_slot;
      remaining <= rem_nxt;
      if (frame_tick) delta <= step;
    end
  end

  assign scroll_active = (remaining != 10'd0) || (delta != 10'd0);

endmodule

// File: doc/platform_scroller.md
PLATFORM_SCROLLER -- requirements
Module: platform_scroller

Interface
REQ-001 Parameter N_PLAT, default 8: number of platform slots scanned; SHALL be >= 2.
REQ-002 Parameter SCROLL_LINE, default 520: doodle_y at or below which landing triggers a scroll.
REQ-003 Parameters DOODLE_H 80, DOODLE_W 61, PLAT_W 80, HIT_TOL 30, GROUND_Y 767, MAX_STEP 16, all in pixels, SHALL set the hit geometry and per-frame scroll limit.
REQ-004 clk  input  1  clock; reset rst, synchronous, active-high.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 frame_tick  input  1  one-cycle pulse per video frame.
REQ-007 falling  input  1  doodle vertical velocity is downward.
REQ-008 doodle_x  input  11  doodle left edge; doodle_y  input  10  doodle top edge.
REQ-009 plat_y  input  N_PLAT x 10  platform top edges; plat_x  input  N_PLAT x 11  platform left edges.
REQ-010 delta  output  10  scroll amount for the current frame.
REQ-011 scroll_active  output  1  scroll still pending or being applied.
REQ-012 hit_valid  output  1  one-cycle landing pulse; hit_idx  output  $clog2(N_PLAT)  landed slot.

Function
REQ-013 FSM states IDLE, SCAN, EVAL; IDLE on reset.
REQ-014 IDLE: frame_tick with falling=1 SHALL latch doodle_x/doodle_y, clear hit flag, set scan index 0, go SCAN; falling=0 SHALL stay IDLE.
REQ-015 SCAN: one slot per cycle, index 0..N_PLAT-1, platform inputs sampled live; after slot N_PLAT-1 go EVAL.
REQ-016 Hit for slot i: plat_y[i] <= dy+DOODLE_H <= plat_y[i]+HIT_TOL AND (plat_x[i]-DOODLE_W <= dx <= plat_x[i]+PLAT_W OR plat_y[i] >= GROUND_Y).
REQ-017 Hit arithmetic SHALL use signed 13-bit intermediates; no wrap on plat_x[i]-DOODLE_W < 0 or sums > 1023.
REQ-018 Multiple hits: lowest index wins; later hits ignored.
REQ-019 EVAL (one cycle): if hit, pulse hit_valid with hit_idx on next cycle; if hit and dy <= SCROLL_LINE, add SCROLL_LINE-dy to remaining; return to IDLE.
REQ-020 remaining: 10-bit, saturates at 1023, never underflows.
REQ-021 Every frame_tick (any state): delta <= min(remaining, MAX_STEP), remaining decremented by that step; delta held until next frame_tick.
REQ-022 Same-cycle frame_tick and EVAL add: remaining_next = sat(remaining - step + add).
REQ-023 frame_tick during SCAN/EVAL SHALL not restart the scan; only the scroll step applies.
REQ-024 scroll_active = (remaining != 0) OR (delta != 0).
REQ-025 Latency: tick at cycle T -> hit_valid at T+N_PLAT+2; scroll starts at next frame_tick.
REQ-026 hit_idx SHALL hold its last value when hit_valid=0.

Reset
REQ-027 rst SHALL force IDLE, delta=0, remaining=0, hit_valid=0, hit_idx=0, scroll_active=0, in any state, including mid-scan or mid-scroll.
REQ-028 First frame_tick after rst deassertion SHALL be honoured normally.

Verification
REQ-029 Basic landing: falling=1, doodle (100,400), slot3 (120,480), others y=0 -> hit_valid, hit_idx=3; subsequent deltas 16 x7, 8, then 0; scroll_active drops after last 0.
REQ-030 Ground below line: slot0 (0,770), doodle (900,690) -> hit_valid, hit_idx=0, delta stays 0.
REQ-031 Priority/no-fall: slots1,5 both hit -> hit_idx=1; same stimulus with falling=0 -> no hit_valid.
REQ-032 Negative edge: slot2 (10,480), doodle (0,400) -> hit (left bound -51), delta sum 120; doodle_x=91 -> no hit.
REQ-033 Accumulate/saturate: second landing add 200 with 50 remaining on same tick -> remaining 234 after step 16; forced adds beyond 1023 clamp at 1023.
REQ-034 Reset mid-scroll: rst during remaining=80 -> delta=0, scroll_active=0 next cycle, no hit_valid.
